present_key_schedule: RTL and testbench

Parametrised PRESENT round-key generator that replaces the initial/updated key select used in the PRESENT-80 datapath. It holds the key register, applies one key-schedule update per accepted step, and presents the current 64-bit round key, its round index, and status to the round datapath. It supports 80- and 128-bit keys. An optional inverse schedule regenerates round keys in reverse order for decryption.

---
 rtl/present_ks_if.sv | 24 ++
 rtl/present_key_schedule.sv | 135 +++++++++++++
 tb/tb_present_key_schedule.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/present_ks_if.sv
// PRESENT key-schedule port bundle: control and key toward the schedule,
// round key and status back to the round datapath.
interface present_ks_if #(
  parameter int KEY_W = 80
) ();
  logic             load;
  logic             dir;
  logic [KEY_W-1:0] key_in;
  logic             step;
  logic [63:0]      round_key;
  logic [5:0]       round_idx;
  logic             key_valid;
  logic             done;

  modport master (
    output load, dir, key_in, step,
    input  round_key, round_idx, key_valid, done
  );

  modport slave (
    input  load, dir, key_in, step,
    output round_key, round_idx, key_valid, done
  );
endinterface

// File: rtl/present_key_schedule.sv
// PRESENT round-key generator for 80- and 128-bit keys. Holds the key
// register, applies one schedule update per accepted step and presents the
// top 64 bits as the round key together with its round index.
// Optional feature macro: KS_DECRYPT_EN adds the inverse schedule (dir=1),
// which walks the round keys from K32 back down to K1.
module present_key_schedule #(
  parameter int KEY_W = 80
) (
  input logic       clk,
  input logic       reset,
  present_ks_if.slave ks
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_key_schedule: KEY_W must be 80 or 128");
  end

  // Round-counter XOR window: [19:15] for 80-bit keys, [66:62] for 128-bit.
  localparam int XOR_LO = (KEY_W == 128) ? 62 : 15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [5:0]       round_idx, idx_nxt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // Rotate left 61, substitute the top nibble(s), fold in the round counter.
  function automatic logic [KEY_W-1:0] fwd_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ c;
    return r;
  endfunction

`ifdef KS_DECRYPT_EN
  logic dir_q, dir_nxt;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // Exact reverse of fwd_update: unfold counter, inverse S-box, rotate right 61.
  function automatic logic [KEY_W-1:0] inv_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       c);
    logic [KEY_W-1:0] r;
    r = k;
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ c;
    r[KEY_W-1 -: 4] = sbox_inv(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox_inv(r[KEY_W-5 -: 4]);
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  // Direction is latched with load and holds for the whole schedule.
  always_ff @(posedge clk) begin
    if (!reset) dir_q <= 1'b0;
    else        dir_q <= dir_nxt;
  end
`else
  logic unused_dir;
  assign unused_dir = ks.dir;
`endif

  // Next-state and next-key selection; load always wins over step.
  always_comb begin
    state_nxt = state_q;
    key_nxt   = key_reg;
    idx_nxt   = round_idx;
`ifdef KS_DECRYPT_EN
    dir_nxt   = dir_q;
`endif
    if (ks.load) begin
      key_nxt   = ks.key_in;
      state_nxt = RUN;
`ifdef KS_DECRYPT_EN
      dir_nxt   = ks.dir;
      idx_nxt   = ks.dir ? 6'd32 : 6'd1;
`else
      idx_nxt   = 6'd1;
`endif
    end else if (ks.step && state_q == RUN) begin
`ifdef KS_DECRYPT_EN
      if (dir_q) begin
        key_nxt = inv_update(key_reg, round_idx[4:0] - 5'd1);
        idx_nxt = round_idx - 6'd1;
        if (round_idx == 6'd2) state_nxt = DONE;
      end else
`endif
      begin
        key_nxt = fwd_update(key_reg, round_idx[4:0]);
        idx_nxt = round_idx + 6'd1;
        if (round_idx == 6'd31) state_nxt = DONE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Key register and round counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_reg   <= '0;
      round_idx <= 6'd0;
    end else begin
      key_reg   <= key_nxt;
      round_idx <= idx_nxt;
    end
  end

  assign ks.round_key = key_reg[KEY_W-1 -: 64];
  assign ks.round_idx = round_idx;
  assign ks.key_valid = (state_q != IDLE);
  assign ks.done      = (state_q == DONE);

endmodule

// File: tb/tb_present_key_schedule.sv
// Self-checking bench for present_key_schedule: an 80-bit and a 128-bit
// instance share control inputs and are compared every cycle against a
// behavioural model of the key schedule, plus literal expectations.
module tb_present_key_schedule;

`ifdef KS_DECRYPT_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  localparam logic [63:0] SBOX_TAB = 64'hC56B90AD3EF84712;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic t_load = 1'b0, t_dir = 1'b0, t_step = 1'b0;
  logic [79:0]  t_key80 = '0;
  logic [127:0] t_key128 = '0;
  bit chk_en = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  present_ks_if #(.KEY_W(80))  i80 ();
  present_ks_if #(.KEY_W(128)) i128 ();

  assign i80.load  = t_load;  assign i128.load  = t_load;
  assign i80.dir   = t_dir;   assign i128.dir   = t_dir;
  assign i80.step  = t_step;  assign i128.step  = t_step;
  assign i80.key_in = t_key80;
  assign i128.key_in = t_key128;

  present_key_schedule #(.KEY_W(80))  dut80  (.clk(clk), .reset(reset), .ks(i80));
  present_key_schedule #(.KEY_W(128)) dut128 (.clk(clk), .reset(reset), .ks(i128));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [127:0] r;
    int           ix;
    int           st;   // 0 idle, 1 run, 2 done
    bit           d;
  } mstate_t;

  mstate_t m [2];
  logic [63:0] fk [2][33];

  function automatic logic [3:0] s_of(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TAB >> (4 * (15 - int'(x)));
    return t[3:0];
  endfunction

  function automatic logic [3:0] sinv_of(input logic [3:0] y);
    for (int x = 0; x < 16; x++)
      if (s_of(4'(x)) == y) return 4'(x);
    return 4'h0;
  endfunction

  function automatic logic [127:0] wmask(input int w);
    return (w == 128) ? {128{1'b1}} : {48'h0, {80{1'b1}}};
  endfunction

  function automatic logic [127:0] m_fwd(input logic [127:0] k, input int w, input int c);
    logic [127:0] r;
    int lo;
    lo = (w == 128) ? 62 : 15;
    r = ((k << 61) | (k >> (w - 61))) & wmask(w);
    r[w-4 +: 4] = s_of(r[w-4 +: 4]);
    if (w == 128) r[w-8 +: 4] = s_of(r[w-8 +: 4]);
    r[lo +: 5] = r[lo +: 5] ^ 5'(c);
    return r;
  endfunction

  function automatic logic [127:0] m_inv(input logic [127:0] k, input int w, input int c);
    logic [127:0] r;
    int lo;
    lo = (w == 128) ? 62 : 15;
    r = k;
    r[lo +: 5] = r[lo +: 5] ^ 5'(c);
    r[w-4 +: 4] = sinv_of(r[w-4 +: 4]);
    if (w == 128) r[w-8 +: 4] = sinv_of(r[w-8 +: 4]);
    return ((r >> 61) | (r << (w - 61))) & wmask(w);
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input int w, input logic rn,
                                     input logic ld, input logic dr, input logic st,
                                     input logic [127:0] key);
    mstate_t n;
    n = s;
    if (!rn) begin
      n.r = '0; n.ix = 0; n.st = 0; n.d = 1'b0;
    end else if (ld) begin
      n.r = key & wmask(w);
      n.d = DEC & dr;
      n.ix = n.d ? 32 : 1;
      n.st = 1;
    end else if (st && s.st == 1) begin
      if (s.d) begin
        n.r = m_inv(s.r, w, s.ix - 1);
        n.ix = s.ix - 1;
        if (n.ix == 1) n.st = 2;
      end else begin
        n.r = m_fwd(s.r, w, s.ix);
        n.ix = s.ix + 1;
        if (n.ix == 32) n.st = 2;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] top64(input mstate_t s, input int w);
    return s.r[w-1 -: 64];
  endfunction

  always @(posedge clk) begin
    m[0] <= m_next(m[0], 80,  reset, t_load, t_dir, t_step, {48'h0, t_key80});
    m[1] <= m_next(m[1], 128, reset, t_load, t_dir, t_step, t_key128);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int j, input logic [63:0] rk, input logic [5:0] ri,
                     input logic kv, input logic dn);
    int w;
    w = j ? 128 : 80;
    chk(j ? "k128_round_key" : "k80_round_key", {64'h0, rk}, {64'h0, top64(m[j], w)});
    chk(j ? "k128_round_idx" : "k80_round_idx", {122'h0, ri}, 128'(m[j].ix));
    chk(j ? "k128_key_valid" : "k80_key_valid", {127'h0, kv}, {127'h0, m[j].st != 0});
    chk(j ? "k128_done" : "k80_done", {127'h0, dn}, {127'h0, m[j].st == 2});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, i80.round_key, i80.round_idx, i80.key_valid, i80.done);
      cmp(1, i128.round_key, i128.round_idx, i128.key_valid, i128.done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic l, input logic d, input logic s,
                     input logic [79:0] k80, input logic [127:0] k128);
    t_load = l; t_dir = d; t_step = s; t_key80 = k80; t_key128 = k128;
    @(negedge clk);
  endtask

  task automatic record_keys();
    fk[0][m[0].ix] = top64(m[0], 80);
    fk[1][m[1].ix] = top64(m[1], 128);
  endtask

  initial begin
    logic [63:0] hold80, hold128;
    logic [79:0]  k32_80;
    logic [127:0] k32_128;
    logic [127:0] rk;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset held low while load is asserted: nothing leaves the reset state.
    cyc(1'b1, 1'b0, 1'b1, {80{1'b1}}, {128{1'b1}});
    cyc(1'b1, 1'b0, 1'b1, {80{1'b1}}, {128{1'b1}});
    chk("rst_round_key", {64'h0, i80.round_key}, 128'h0);
    chk("rst_round_idx", {122'h0, i80.round_idx}, 128'h0);
    chk("rst_key_valid", {127'h0, i128.key_valid}, 128'h0);

    // Forward schedule from key 0.
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("load0_key80", {64'h0, i80.round_key}, 128'h0);
    chk("load0_idx80", {122'h0, i80.round_idx}, 128'd1);
    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("step1_key80", {64'h0, i80.round_key}, {64'h0, 64'hC000000000000000});
    chk("step1_idx80", {122'h0, i80.round_idx}, 128'd2);
    chk("step1_key128", {64'h0, i128.round_key}, {64'h0, 64'hCC00000000000000});
    chk("mdl_step1_key128", {64'h0, top64(m[1], 128)}, {64'h0, 64'hCC00000000000000});
    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("step2_key80", {64'h0, i80.round_key}, {64'h0, 64'h5000180000000001});
    chk("step2_idx80", {122'h0, i80.round_idx}, 128'd3);
    chk("mdl_step2_key80", {64'h0, top64(m[0], 80)}, {64'h0, 64'h5000180000000001});
    repeat (29) cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("fwd_done80", {127'h0, i80.done}, 128'h1);
    chk("fwd_idx80", {122'h0, i80.round_idx}, 128'd32);
    chk("fwd_done128", {127'h0, i128.done}, 128'h1);
    hold80 = i80.round_key;
    hold128 = i128.round_key;
    repeat (3) cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("extra_key80", {64'h0, i80.round_key}, {64'h0, hold80});
    chk("extra_key128", {64'h0, i128.round_key}, {64'h0, hold128});
    chk("extra_idx80", {122'h0, i80.round_idx}, 128'd32);

    // Load together with step mid-run: the load wins.
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, '0, '0);
    cyc(1'b1, 1'b0, 1'b1, {80{1'b1}}, {128{1'b1}});
    chk("ldstep_key80", {64'h0, i80.round_key}, {64'h0, 64'hFFFFFFFFFFFFFFFF});
    chk("ldstep_idx80", {122'h0, i80.round_idx}, 128'd1);
    chk("ldstep_key128", {64'h0, i128.round_key}, {64'h0, 64'hFFFFFFFFFFFFFFFF});
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

`ifdef KS_DECRYPT_EN
    // Inverse schedule: run forward, reload K32 state with dir=1, walk back.
    for (int pass = 0; pass < 2; pass++) begin
      rk = (pass == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      cyc(1'b1, 1'b0, 1'b0, rk[79:0], rk);
      record_keys();
      for (int s = 0; s < 31; s++) begin
        cyc(1'b0, 1'b0, 1'b1, '0, '0);
        record_keys();
      end
      k32_80 = m[0].r[79:0];
      k32_128 = m[1].r;
      cyc(1'b1, 1'b1, 1'b0, k32_80, k32_128);
      chk("inv_load_idx80", {122'h0, i80.round_idx}, 128'd32);
      for (int s = 0; s < 31; s++) begin
        cyc(1'b0, 1'b0, 1'b1, '0, '0);
        chk("inv_rev_key80", {64'h0, i80.round_key}, {64'h0, fk[0][31 - s]});
        chk("inv_rev_key128", {64'h0, i128.round_key}, {64'h0, fk[1][31 - s]});
      end
      chk("inv_final_idx80", {122'h0, i80.round_idx}, 128'd1);
      chk("inv_final_done80", {127'h0, i80.done}, 128'h1);
      if (pass == 0) begin
        chk("inv_final_key80", {64'h0, i80.round_key}, 128'h0);
        chk("inv_final_key128", {64'h0, i128.round_key}, 128'h0);
      end
    end
`else
    // Without the inverse schedule, dir=1 on load behaves as a forward load.
    cyc(1'b1, 1'b1, 1'b0, '0, '0);
    chk("dir_ignored_idx80", {122'h0, i80.round_idx}, 128'd1);
    cyc(1'b0, 1'b1, 1'b1, '0, '0);
    chk("dir_ignored_key80", {64'h0, i80.round_key}, {64'h0, 64'hC000000000000000});
`endif

    // Randomized phase with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      reset = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, rk[79:0], rk);
    end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
